// File: rtl/tdc_multichannel_capture_if.sv
// Signal bundle between a measurement controller (master) and the
// multi-channel coarse TDC capture block (slave).
interface tdc_multichannel_capture_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
  // No valid/ready pair: start is a one-cycle request, honoured only when the
  // block is not busy; done is a one-cycle completion pulse; busy is a level.
  logic              start;
  logic [N_CH-1:0]   stop_in;
  logic [N_CH-1:0]   stop_pol;
  logic [SEL_W-1:0]  rd_sel;
  logic [CNT_W:0]    rd_data;
  logic              busy;
  logic              done;

  modport master (
    output start, stop_in, stop_pol, rd_sel,
    input  rd_data, busy, done
  );

  modport slave (
    input  start, stop_in, stop_pol, rd_sel,
    output rd_data, busy, done
  );
endinterface

// File: rtl/tdc_multichannel_capture.sv
// Coarse multi-channel TDC: a start pulse arms a saturating cycle counter and
// the counter value at the first synchronised stop edge of each channel is held.
module tdc_multichannel_capture #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  tdc_multichannel_capture_if.slave     bus,
  output logic [1:0]                    dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  ts_q [N_CH];
  logic [CNT_W-1:0]  ts_d [N_CH];
  logic [N_CH-1:0]   valid_q, valid_d;
  logic [N_CH-1:0]   s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [N_CH-1:0]   edge_hit;
  logic [CNT_W:0]    rd_data_q, rd_data_d;
  logic              done_q, done_d;

  // s1 is the metastability stage; edges are judged on s2 against s3.
  assign edge_hit = (bus.stop_pol & s2_q & ~s3_q) | (~bus.stop_pol & ~s2_q & s3_q);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ts_d      = ts_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    rd_data_d = '0;
    s1_d      = bus.stop_in;
    s2_d      = s1_q;
    s3_d      = s2_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          count_d = '0;
          valid_d = '0;
          for (int i = 0; i < N_CH; i++) ts_d[i] = '0;
        end
      end
      S_RUN: begin
        if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
        for (int i = 0; i < N_CH; i++) begin
          if (edge_hit[i] && !valid_q[i]) begin
            ts_d[i]    = count_q;
            valid_d[i] = 1'b1;
          end
        end
        // Completion looks at the registered flags, so it lands one edge
        // after the last capture; a capture on the timeout edge still counts.
        if ((&valid_q) || (count_q == CNT_MAX)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < N_CH; i++) begin
      if (bus.rd_sel == SEL_W'(i)) rd_data_d = {valid_q[i], ts_q[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      valid_q   <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < N_CH; i++) ts_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
      for (int i = 0; i < N_CH; i++) ts_q[i] <= ts_d[i];
    end
  end

  assign bus.busy    = (state_q == S_RUN);
  assign bus.done    = done_q;
  assign bus.rd_data = rd_data_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_tdc_multichannel_capture.sv
// Bench for tdc_multichannel_capture: a 4-channel/8-bit instance and a
// 3-channel/4-bit instance checked against an edge-arithmetic timing model.
module tb_tdc_multichannel_capture;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       drv_start;
  logic [3:0] drv_stop;
  logic [3:0] drv_pol;
  logic [1:0] drv_sel;
  bit         use_b;

  tdc_multichannel_capture_if #(.N_CH(4), .CNT_W(8)) ifa ();
  tdc_multichannel_capture_if #(.N_CH(3), .CNT_W(4)) ifb ();
  logic [1:0] dbg_a, dbg_b;

  assign ifa.start    = drv_start & ~use_b;
  assign ifa.stop_in  = drv_stop;
  assign ifa.stop_pol = drv_pol;
  assign ifa.rd_sel   = drv_sel;
  assign ifb.start    = drv_start & use_b;
  assign ifb.stop_in  = drv_stop[2:0];
  assign ifb.stop_pol = drv_pol[2:0];
  assign ifb.rd_sel   = drv_sel;

  tdc_multichannel_capture #(.N_CH(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .dbg_state(dbg_a)
  );
  tdc_multichannel_capture #(.N_CH(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .dbg_state(dbg_b)
  );

  logic       obs_busy, obs_done;
  logic [8:0] obs_rd;
  assign obs_busy = use_b ? ifb.busy : ifa.busy;
  assign obs_done = use_b ? ifb.done : ifa.done;
  assign obs_rd   = use_b ? {4'b0, ifb.rd_data} : ifa.rd_data;

  // ---------------- scoreboard state ----------------
  int         n_cmp;
  int         n_err;
  logic [8:0] exp_q[$];

  // Per-run stimulus description: k_cfg[i] = edge at which stop i is first
  // sampled at its active level (0 = never, -1 = already active before start).
  int         k_cfg[4];
  logic [3:0] pol_cfg;
  int         spur_start;

  // ---------------- driver + model for one measurement ----------------
  task automatic measure(input string tag);
    int cw, nch, maxc, maxk, done_edge, last, ch;
    bit cap[4];
    bit all_cap;
    logic [8:0] want;
    cw   = use_b ? 4 : 8;
    nch  = use_b ? 3 : 4;
    maxc = (1 << cw) - 1;
    all_cap = 1'b1;
    maxk = 0;
    for (int i = 0; i < 4; i++) begin
      // sampled active on edge k -> captured on edge k+2 holding count k+1
      cap[i] = (k_cfg[i] >= 1) && (k_cfg[i] + 1 <= maxc);
      if (i < nch) begin
        if (!cap[i]) all_cap = 1'b0;
        else if (k_cfg[i] > maxk) maxk = k_cfg[i];
      end
    end
    done_edge = maxc + 1;
    if (all_cap && (maxk + 3 < done_edge)) done_edge = maxk + 3;

    drv_pol   = pol_cfg;
    drv_sel   = 2'd0;
    drv_start = 1'b0;
    for (int i = 0; i < 4; i++) drv_stop[i] = (k_cfg[i] < 0) ? pol_cfg[i] : ~pol_cfg[i];
    repeat (4) @(negedge clk);
    drv_start = 1'b1;
    last = done_edge + 3;
    for (int e = 0; e <= last; e++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (obs_busy !== (e < done_edge)) begin
        n_err++;
        $display("FAIL %s busy edge=%0d got=%b want=%b", tag, e, obs_busy, (e < done_edge));
      end
      n_cmp++;
      if (obs_done !== (e == done_edge)) begin
        n_err++;
        $display("FAIL %s done edge=%0d got=%b want=%b", tag, e, obs_done, (e == done_edge));
      end
      if (e >= 1) begin
        ch = int'(drv_sel);
        want = '0;
        if (ch < nch && cap[ch] && (k_cfg[ch] + 2 <= e - 1))
          want = 9'((1 << cw) | (k_cfg[ch] + 1));
        n_cmp++;
        if (obs_rd !== want) begin
          n_err++;
          $display("FAIL %s rd_data edge=%0d sel=%0d got=%h want=%h", tag, e, ch, obs_rd, want);
        end
      end
      // stimulus for edge e+1
      drv_start = ((e + 1) == spur_start);
      drv_sel   = 2'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) begin
        if (k_cfg[i] < 0)               drv_stop[i] = pol_cfg[i];
        else if (k_cfg[i] == 0)         drv_stop[i] = (e + 1 > done_edge) ? 1'($urandom_range(0, 1)) : ~pol_cfg[i];
        else if (e + 1 < k_cfg[i])      drv_stop[i] = ~pol_cfg[i];
        else if (e + 1 <= k_cfg[i] + 1) drv_stop[i] = pol_cfg[i];
        else                            drv_stop[i] = 1'($urandom_range(0, 1));
      end
    end
    drv_start = 1'b0;
    // final readout sweep while results are held
    for (int c = 0; c < 4; c++) begin
      if (c < nch && cap[c]) exp_q.push_back(9'((1 << cw) | (k_cfg[c] + 1)));
      else                   exp_q.push_back(9'd0);
      drv_sel = 2'(c);
      @(posedge clk);
      @(negedge clk);
      want = exp_q.pop_front();
      n_cmp++;
      if (obs_rd !== want) begin
        n_err++;
        $display("FAIL %s readout ch=%0d got=%h want=%h", tag, c, obs_rd, want);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; use_b = 1'b0;
    drv_start = 1'b0; drv_stop = '0; drv_pol = 4'hF; drv_sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (ifa.busy !== 1'b0)    begin n_err++; $display("FAIL reset busy_a got=%b want=0", ifa.busy); end
    n_cmp++; if (ifa.done !== 1'b0)    begin n_err++; $display("FAIL reset done_a got=%b want=0", ifa.done); end
    n_cmp++; if (ifa.rd_data !== 9'd0) begin n_err++; $display("FAIL reset rd_a got=%h want=0", ifa.rd_data); end
    n_cmp++; if (ifb.busy !== 1'b0)    begin n_err++; $display("FAIL reset busy_b got=%b want=0", ifb.busy); end
    n_cmp++; if (ifb.rd_data !== 5'd0) begin n_err++; $display("FAIL reset rd_b got=%h want=0", ifb.rd_data); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (ifa.busy !== 1'b0)    begin n_err++; $display("FAIL idle busy_a got=%b want=0", ifa.busy); end
  endtask

  task automatic test_basic();
    use_b = 1'b0; pol_cfg = 4'hF; spur_start = -1;
    k_cfg = '{10, 0, 0, 0};
    measure("basic");
  endtask

  task automatic test_all_channels();
    use_b = 1'b0; pol_cfg = 4'hF; spur_start = -1;
    k_cfg = '{5, 20, 20, 40};
    measure("all_ch");
  endtask

  task automatic test_falling_preasserted();
    use_b = 1'b0; pol_cfg = 4'b1101; spur_start = -1;
    k_cfg = '{-1, 7, 3, 0};
    measure("falling");
  endtask

  task automatic test_timeout();
    use_b = 1'b1; pol_cfg = 4'hF; spur_start = -1;
    k_cfg = '{0, 0, 3, 0};
    measure("timeout");
    // capture landing exactly on the timeout edge
    k_cfg = '{3, 14, 0, 0};
    measure("timeout_edge");
  endtask

  task automatic test_restart_ignore();
    use_b = 1'b0; pol_cfg = 4'hF;
    spur_start = 8;
    k_cfg = '{5, 20, 30, 12};
    measure("start_in_run");
    spur_start = -1;
    k_cfg = '{0, 15, 0, 3};
    measure("restart");
  endtask

  task automatic test_back_to_back();
    int r;
    for (int run = 0; run < 6; run++) begin
      use_b = (run % 2) == 1;
      pol_cfg = 4'($urandom);
      spur_start = int'($urandom_range(1, 3));
      for (int i = 0; i < 4; i++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0)      k_cfg[i] = 0;
        else if (r == 1) k_cfg[i] = -1;
        else             k_cfg[i] = int'($urandom_range(1, use_b ? 17 : 120));
      end
      measure(use_b ? "rand_b" : "rand_a");
    end
  endtask

  task automatic test_reset_mid_run();
    use_b = 1'b0;
    drv_pol = 4'hF; drv_stop = '0; drv_sel = '0; drv_start = 1'b0;
    repeat (4) @(negedge clk);
    drv_start = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      @(posedge clk);
      @(negedge clk);
      drv_start   = 1'b0;
      drv_stop[0] = (e + 1 >= 3);
    end
    n_cmp++; if (ifa.rd_data !== 9'h104) begin n_err++; $display("FAIL midrst pre rd got=%h want=104", ifa.rd_data); end
    rst = 1'b1; drv_start = 1'b1;
    for (int e = 13; e <= 14; e++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if (ifa.busy !== 1'b0) begin n_err++; $display("FAIL midrst busy edge=%0d got=%b want=0", e, ifa.busy); end
      n_cmp++; if (ifa.rd_data !== 9'd0) begin n_err++; $display("FAIL midrst rd edge=%0d got=%h want=0", e, ifa.rd_data); end
    end
    rst = 1'b0; drv_start = 1'b0;
    for (int e = 0; e < 20; e++) begin
      drv_stop = 4'($urandom);
      drv_sel  = 2'($urandom_range(0, 3));
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if (ifa.busy !== 1'b0) begin n_err++; $display("FAIL idle_busy cyc=%0d got=%b want=0", e, ifa.busy); end
      n_cmp++; if (ifa.done !== 1'b0) begin n_err++; $display("FAIL idle_done cyc=%0d got=%b want=0", e, ifa.done); end
      n_cmp++; if (ifa.rd_data !== 9'd0) begin n_err++; $display("FAIL idle_rd cyc=%0d got=%h want=0", e, ifa.rd_data); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    spur_start = -1;
    test_reset();
    test_basic();
    test_all_channels();
    test_falling_preasserted();
    test_timeout();
    test_restart_ignore();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tdc_multichannel_capture.md
# tdc_multichannel_capture

Parametrised multi-channel coarse time-to-digital converter for the micro-tile TDC tile. A single `start` pulse arms a shared cycle counter. Each of `N_CH` asynchronous stop inputs is synchronised and edge-detected, and the counter value at its first qualifying edge is latched. Per-channel timestamps and valid flags are read out through a registered select port, which the top-level wrapper maps onto the dedicated `ui_in`/`uo_out`/`uio` pins.

## Interface
Parameters:
- `N_CH`, 4, number of stop channels (≥1)
- `CNT_W`, 8, timestamp/counter width (≥2)
- `SEL_W`, max(1, clog2(`N_CH`)), readout select width (derived)

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: synchronous pulse that arms a measurement
- `stop_in` in `N_CH`: asynchronous stop lines, one per channel
- `stop_pol` in `N_CH`: per-channel edge select (1 = rising, 0 = falling); static while `busy`
- `rd_sel` in `SEL_W`: channel to read
- `rd_data` out `CNT_W`+1: registered `{valid, timestamp}` of the selected channel
- `busy` out 1: high while in RUN
- `done` out 1: one-cycle pulse on entry to DONE

## Operation
- FSM states:
  - IDLE: reset state; waiting for `start`.
  - RUN: counting and capturing.
  - DONE: results held for readout.
- IDLE→RUN, or DONE→RUN: when `start`=1. On that edge, `count`←0, every `ts[i]`←0 and every `valid[i]`←0.
- `start` is ignored while in RUN.
- In RUN:
  - `count` increments by 1 each cycle.
  - `count` saturates at 2^`CNT_W`−1 and never wraps.
- Synchroniser, per channel, always running in every state:
  - Flops `s1`←`stop_in`, `s2`←`s1`, `s3`←`s2`.
  - Edge condition: `stop_pol` ? (`s2` & ~`s3`) : (~`s2` & `s3`).
- Capture:
  - In RUN, an edge on a channel with `valid[i]`=0 sets `ts[i]`←`count` and `valid[i]`←1.
  - Only the first hit per run is captured; later edges are ignored.
  - Edges in IDLE or DONE are ignored.
  - A line already at its active level when `start` arrives produces no edge.
- RUN→DONE, whichever comes first:
  - all `valid` bits are 1; the transition occurs on the edge after the last capture;
  - `count` = 2^`CNT_W`−1 at an edge (timeout).
- An edge coinciding with the timeout edge is still captured.
- Channels uncaptured at timeout keep `valid`=0 and `ts`=0.
- Multiple channels may capture on the same edge; each gets the same `count`.
- `done`=1 for exactly the first cycle in DONE.
- `busy`=1 exactly while in RUN.
- DONE holds results until the next `start` or `rst`.
- Readout:
  - `rd_data`←{`valid[rd_sel]`, `ts[rd_sel]`} every cycle, in every state.
  - `rd_sel` ≥ `N_CH` returns 0.

## Timing
- Reset state: IDLE, `count`=0, all `ts`/`valid`/`s1..s3`=0, `rd_data`=0, `busy`=0, `done`=0.
- Reset asserted mid-run: IDLE on the next edge and all captures cleared; `rst` has priority over `start`.
- Counter origin: take the edge that samples `start`=1 as edge 0.
  - `count`=n between edges n and n+1.
  - `busy` rises after edge 0.
- Capture latency: if `stop_in` is first sampled at its active level on edge k (k ≥ 1), `ts` = k+1.
  - The fixed +1 synchroniser offset is removed in software, not in RTL.
- Pulse width: a stop pulse must be held for ≥2 clock edges to be detected.
- Readout latency: 1 cycle from `rd_sel` change to `rd_data`.
- Timeout: with no stops, DONE is entered on edge 2^`CNT_W`.
  - `done` is high in the cycle after that edge.
  - `busy` falls on the same edge.

## Test plan
- Basic: defaults, `stop_pol`=4'hF; `start` at edge 0, `stop_in[0]` high from edge 10. Required: `ts[0]`=11, `valid[0]`=1, `rd_sel`=0 → `rd_data`=9'h10B.
- All channels: ch0..3 high from edges 5, 20, 20, 40. Required:
  - `ts` = 6, 21, 21, 41, all valid;
  - `done` pulses one cycle after the edge-41 capture;
  - `busy` low thereafter.
- Falling edge and pre-asserted lines: `stop_pol[1]`=0 and `stop_in[1]` high before `start`, dropping low from edge 7. Required: `ts[1]`=8.
  - Also: a rising-polarity channel already high at `start` never captures.
- Timeout: `CNT_W`=4, only ch2 fires, at edge 3. Required:
  - DONE on edge 16;
  - ch2 = {1, 4'd4};
  - other channels {0, 0};
  - `rd_sel`=5 (out of range, `N_CH`=4, `SEL_W`=2 → test with `N_CH`=3) → 0.
- Restart and ignore: a second `start` during RUN has no effect. A `start` in DONE clears all `valid` and re-measures with fresh timestamps. Extra edges after capture leave `ts` unchanged.
- Reset mid-run: assert `rst` at count 12. Required: `busy`=0, `rd_data`=0 and state IDLE on the next edge, and stop edges are ignored until the next `start`.
